// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared definitions for the SRAM arbiter: FSM state encoding and the
//   requester index constants used by the grant logic and the top level.
//   Optional feature macro: SRAM_ARB_RR_EN (see sram_arb_prio).

package sram_arb_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/sram_arb_prio.sv
// sram_arb_prio
//   Two-way grant selection between the fetch and data requesters.
//   Macro SRAM_ARB_RR_EN:
//     defined   - round-robin; after each grant priority passes to the other
//                 port, data port has priority out of reset.
//     undefined - fixed priority, data port always wins.
// Ports
//   clk, rst     clock / sync active-high reset (round-robin build only)
//   advance      a grant was taken this cycle (round-robin build only)
//   i_valid      fetch request pending
//   d_valid      data request pending
//   grant_valid  at least one request pending
//   grant_idx    winning port (PORT_FETCH / PORT_DATA)

module sram_arb_prio
   import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
   input  logic clk,
   input  logic rst,
   input  logic advance,
`endif
   input  logic i_valid,
   input  logic d_valid,
   output logic grant_valid,
   output logic grant_idx
);

`ifdef SRAM_ARB_RR_EN
   logic prio_q;  // port that wins a tie

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= PORT_DATA;
      end else if (advance) begin
         prio_q <= ~grant_idx;
      end
   end

   always_comb begin
      grant_valid = i_valid | d_valid;
      if (i_valid && d_valid) begin
         grant_idx = prio_q;
      end else begin
         grant_idx = d_valid ? PORT_DATA : PORT_FETCH;
      end
   end
`else
   always_comb begin
      grant_valid = i_valid | d_valid;
      grant_idx   = d_valid ? PORT_DATA : PORT_FETCH;
   end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port OpenRAM-style SRAM between the instruction fetch
//   port (read-only) and the data port (read/write). An access takes two
//   cycles: the granted request drives the SRAM strobes combinationally in
//   IDLE, the macro completes it during ACCESS, and the response pulses the
//   cycle after. Arbitration mode is selected by macro SRAM_ARB_RR_EN.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_req_*/i_rsp_*          fetch request / response
//   d_req_*/d_rsp_*          data request / response (write ack has rdata 0)
//   sram_csb/web/addr/din/wmask, sram_dout   SRAM macro interface
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | no access in flight; grant and drive SRAM from a request
//   ST_ACCESS | SRAM operating on latched request; capture dout at end

module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 15,
   parameter int NUM_WMASKS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   output logic                  i_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   output logic                  i_rsp_valid,
   output logic [DATA_WIDTH-1:0] i_rsp_rdata,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic                  d_req_we,
   input  logic [ADDR_WIDTH-1:0] d_req_addr,
   input  logic [DATA_WIDTH-1:0] d_req_wdata,
   input  logic [NUM_WMASKS-1:0] d_req_wmask,
   output logic                  d_rsp_valid,
   output logic [DATA_WIDTH-1:0] d_rsp_rdata,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   output logic [NUM_WMASKS-1:0] sram_wmask,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   state_t state_q, state_d;
   logic   grant_valid, grant_idx;
   logic   hs;          // request accepted this cycle
   logic   grant_q;     // port owning the access in flight
   logic   we_q;        // access in flight is a write

   sram_arb_prio u_prio (
`ifdef SRAM_ARB_RR_EN
      .clk         (clk),
      .rst         (rst),
      .advance     (hs),
`endif
      .i_valid     (i_req_valid),
      .d_valid     (d_req_valid),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      state_d     = state_q;
      hs          = 1'b0;
      i_req_ready = 1'b0;
      d_req_ready = 1'b0;
      sram_csb    = 1'b1;
      sram_web    = 1'b1;
      sram_addr   = '0;
      sram_din    = '0;
      sram_wmask  = '0;
      case (state_q)
         ST_IDLE: begin
            // Gated by rst so nothing is accepted or strobed while in reset.
            if (!rst && grant_valid) begin
               hs       = 1'b1;
               state_d  = ST_ACCESS;
               sram_csb = 1'b0;
               if (grant_idx == PORT_DATA) begin
                  d_req_ready = 1'b1;
                  sram_web    = ~d_req_we;
                  sram_addr   = d_req_addr;
                  sram_din    = d_req_wdata;
                  sram_wmask  = d_req_wmask;
               end else begin
                  i_req_ready = 1'b1;
                  sram_addr   = i_req_addr;
               end
            end
         end
         ST_ACCESS: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= PORT_FETCH;
         we_q        <= 1'b0;
         i_rsp_valid <= 1'b0;
         d_rsp_valid <= 1'b0;
         i_rsp_rdata <= '0;
         d_rsp_rdata <= '0;
      end else begin
         state_q     <= state_d;
         i_rsp_valid <= 1'b0;
         d_rsp_valid <= 1'b0;
         if (hs) begin
            grant_q <= grant_idx;
            we_q    <= (grant_idx == PORT_DATA) && d_req_we;
         end
         // Read data is valid after the negedge inside ACCESS.
         if (state_q == ST_ACCESS) begin
            if (grant_q == PORT_DATA) begin
               d_rsp_valid <= 1'b1;
               d_rsp_rdata <= we_q ? '0 : sram_dout;
            end else begin
               i_rsp_valid <= 1'b1;
               i_rsp_rdata <= sram_dout;
            end
         end
      end
   end

endmodule
